// File: rtl/data_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// data_bus_arbiter_if
//
// Bundles every signal around the data-memory bus arbiter: the two requester
// ports (m0 = core load/store, m1 = loader/debug DMA) and the memory side.
//
// Modports:
//   slave  - arbiter view: requester requests/fields and mem_read_data are
//            inputs; grants, read returns and mem_* drives are outputs.
//   master - environment view (requesters plus memory): the mirror image.
//
// Per requester N (0/1):
//   mN_req, mN_lock, mN_address, mN_write_enable, mN_byte_enable,
//   mN_write_data                               requester -> arbiter
//   mN_grant, mN_read_valid, mN_read_data       arbiter   -> requester
// Memory side:
//   mem_address, mem_read_enable, mem_write_enable, mem_byte_enable,
//   mem_write_data                              arbiter   -> memory
//   mem_read_data                               memory    -> arbiter
// ----------------------------------------------------------------------------
interface data_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // requester 0
    logic                  m0_req;
    logic                  m0_lock;
    logic [ADDR_WIDTH-1:0] m0_address;
    logic                  m0_write_enable;
    logic [BE_WIDTH-1:0]   m0_byte_enable;
    logic [DATA_WIDTH-1:0] m0_write_data;
    logic                  m0_grant;
    logic                  m0_read_valid;
    logic [DATA_WIDTH-1:0] m0_read_data;

    // requester 1
    logic                  m1_req;
    logic                  m1_lock;
    logic [ADDR_WIDTH-1:0] m1_address;
    logic                  m1_write_enable;
    logic [BE_WIDTH-1:0]   m1_byte_enable;
    logic [DATA_WIDTH-1:0] m1_write_data;
    logic                  m1_grant;
    logic                  m1_read_valid;
    logic [DATA_WIDTH-1:0] m1_read_data;

    // memory side
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read_enable;
    logic                  mem_write_enable;
    logic [BE_WIDTH-1:0]   mem_byte_enable;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  m0_req, m0_lock, m0_address, m0_write_enable, m0_byte_enable, m0_write_data,
        output m0_grant, m0_read_valid, m0_read_data,
        input  m1_req, m1_lock, m1_address, m1_write_enable, m1_byte_enable, m1_write_data,
        output m1_grant, m1_read_valid, m1_read_data,
        output mem_address, mem_read_enable, mem_write_enable, mem_byte_enable, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output m0_req, m0_lock, m0_address, m0_write_enable, m0_byte_enable, m0_write_data,
        input  m0_grant, m0_read_valid, m0_read_data,
        output m1_req, m1_lock, m1_address, m1_write_enable, m1_byte_enable, m1_write_data,
        input  m1_grant, m1_read_valid, m1_read_data,
        input  mem_address, mem_read_enable, mem_write_enable, mem_byte_enable, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// ----------------------------------------------------------------------------
// data_bus_arbiter
//
// Shares the single data-memory bus between requester 0 (core load/store)
// and requester 1 (loader/debug DMA). Arbitration is round-robin with an
// optional lock that keeps the grant on one requester across multi-beat
// transfers, bounded by LOCK_MAX consecutive locked grants (0 = unbounded).
// The grant is combinational in the request cycle; the memory answers reads
// one cycle later and the arbiter steers that data to whoever issued the read.
//
// Ports:
//   clock   - system clock, all state updates on posedge
//   reset   - synchronous, active-high reset
//   bus_if  - data_bus_arbiter_if.slave: both requester ports and the
//             memory-side drives/returns
//
// Parameters:
//   ADDR_WIDTH - address width
//   DATA_WIDTH - data width (byte enables are DATA_WIDTH/8 wide)
//   LOCK_MAX   - max consecutive locked grants before a forced handoff
// ----------------------------------------------------------------------------
module data_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 15
) (
    input  logic              clock,
    input  logic              reset,
    data_bus_arbiter_if.slave bus_if
);
    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_NEED  = $clog2(LOCK_MAX + 1);
    localparam int CNT_WIDTH = (CNT_NEED > 4) ? CNT_NEED : 4;
    localparam logic [CNT_WIDTH-1:0] LOCK_LIMIT = CNT_WIDTH'(LOCK_MAX);
    localparam bit LIMIT_EN = (LOCK_MAX != 0);

    // Saturating increment: with the limit disabled the count would otherwise
    // wrap during a very long lock; saturating keeps it meaningful.
    function automatic logic [CNT_WIDTH-1:0] count_inc(input logic [CNT_WIDTH-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_WIDTH'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Requester views
    // ------------------------------------------------------------------------
    logic [1:0] req;
    logic [1:0] lock;

    assign req  = {bus_if.m1_req,  bus_if.m0_req};
    assign lock = {bus_if.m1_lock, bus_if.m0_lock};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                 last_grant_q, last_grant_d;
    logic                 locked_q,     locked_d;
    logic                 lock_owner_q, lock_owner_d;
    logic [CNT_WIDTH-1:0] lock_count_q, lock_count_d;
    logic                 rd_pending_q, rd_pending_d;
    logic                 rd_owner_q,   rd_owner_d;

    // ------------------------------------------------------------------------
    // Grant decision (combinational, same cycle as the request)
    // ------------------------------------------------------------------------
    logic grant_vld;
    logic grant_sel;

    always_comb begin : arbitrate
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        if (!reset) begin
            if (locked_q && req[lock_owner_q]) begin
                grant_vld = 1'b1;
                grant_sel = lock_owner_q;
            end else if (req[0] ^ req[1]) begin
                grant_vld = 1'b1;
                grant_sel = req[1];
            end else if (req[0] & req[1]) begin
                // Tie: the requester that did not win last time goes first.
                grant_vld = 1'b1;
                grant_sel = ~last_grant_q;
            end
        end
    end

    assign bus_if.m0_grant = grant_vld & ~grant_sel;
    assign bus_if.m1_grant = grant_vld &  grant_sel;

    // ------------------------------------------------------------------------
    // Memory-side drive: mirror the granted requester, all zero otherwise
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] sel_address;
    logic                  sel_write_enable;
    logic [BE_WIDTH-1:0]   sel_byte_enable;
    logic [DATA_WIDTH-1:0] sel_write_data;

    assign sel_address      = grant_sel ? bus_if.m1_address      : bus_if.m0_address;
    assign sel_write_enable = grant_sel ? bus_if.m1_write_enable : bus_if.m0_write_enable;
    assign sel_byte_enable  = grant_sel ? bus_if.m1_byte_enable  : bus_if.m0_byte_enable;
    assign sel_write_data   = grant_sel ? bus_if.m1_write_data   : bus_if.m0_write_data;

    assign bus_if.mem_address      = grant_vld ? sel_address : '0;
    assign bus_if.mem_read_enable  = grant_vld & ~sel_write_enable;
    assign bus_if.mem_write_enable = grant_vld &  sel_write_enable;
    assign bus_if.mem_write_data   = grant_vld ? sel_write_data : '0;

    // Reads always fetch the full word; lane selection is the requester's job.
    assign bus_if.mem_byte_enable  = !grant_vld       ? '0 :
                                     sel_write_enable ? sel_byte_enable :
                                                        {BE_WIDTH{1'b1}};

    // ------------------------------------------------------------------------
    // Read return steering
    // ------------------------------------------------------------------------
    // rd_pending_q still holds the pre-reset value during the first reset
    // cycle; gating with reset keeps a read accepted just before reset from
    // surfacing while reset is high.
    logic rd_return;

    assign rd_return = rd_pending_q & ~reset;

    assign bus_if.m0_read_valid = rd_return & ~rd_owner_q;
    assign bus_if.m1_read_valid = rd_return &  rd_owner_q;
    assign bus_if.m0_read_data  = bus_if.m0_read_valid ? bus_if.mem_read_data : '0;
    assign bus_if.m1_read_data  = bus_if.m1_read_valid ? bus_if.mem_read_data : '0;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] count_next;
    logic                 lock_continues;

    always_comb begin : next_state
        last_grant_d   = last_grant_q;
        locked_d       = 1'b0;
        lock_owner_d   = lock_owner_q;
        lock_count_d   = '0;
        rd_pending_d   = 1'b0;
        rd_owner_d     = rd_owner_q;
        lock_continues = locked_q && (lock_owner_q == grant_sel);
        count_next     = '0;

        // Any cycle without a lock-carrying grant drops the lock: either the
        // owner released lock while granted, the owner stopped requesting,
        // or nobody holds it.
        if (grant_vld) begin
            last_grant_d = grant_sel;

            if (lock[grant_sel]) begin
                // A fresh acquisition (including taking over from an owner
                // that went idle) starts counting from one.
                count_next   = count_inc(lock_continues ? lock_count_q : '0);
                lock_owner_d = grant_sel;
                if (LIMIT_EN && (count_next == LOCK_LIMIT)) begin
                    // Forced handoff: last_grant_d already names the owner,
                    // so a waiting requester wins the next tie.
                    locked_d     = 1'b0;
                    lock_count_d = '0;
                end else begin
                    locked_d     = 1'b1;
                    lock_count_d = count_next;
                end
            end

            if (!sel_write_enable) begin
                rd_pending_d = 1'b1;
                rd_owner_d   = grant_sel;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= 1'b1;   // requester 0 wins the first tie
            locked_q     <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_count_q <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            locked_q     <= locked_d;
            lock_owner_q <= lock_owner_d;
            lock_count_q <= lock_count_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end
endmodule

// File: tb/tb_data_bus_arbiter.sv
module tb_data_bus_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_if (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // memory environment: 256 words, read data valid the cycle after read enable
  bit   [31:0] mem [256] = '{64: 32'h1111_0100, 128: 32'h2222_0200, default: 32'h0};
  logic [31:0] rdata_q = 32'h0;

  always @(posedge clock) begin
    if (bus.mem_write_enable) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_byte_enable[b]) mem[bus.mem_address[9:2]][8*b +: 8] <= bus.mem_write_data[8*b +: 8];
      end
    end
    if (bus.mem_read_enable) rdata_q <= mem[bus.mem_address[9:2]];
  end
  assign bus.mem_read_data = rdata_q;

  // requester drive
  logic        r_req [2];
  logic        r_lock[2];
  logic        r_we  [2];
  logic [31:0] r_addr[2];
  logic [3:0]  r_be  [2];
  logic [31:0] r_wd  [2];

  task automatic apply();
    bus.m0_req = r_req[0]; bus.m0_lock = r_lock[0]; bus.m0_write_enable = r_we[0];
    bus.m0_address = r_addr[0]; bus.m0_byte_enable = r_be[0]; bus.m0_write_data = r_wd[0];
    bus.m1_req = r_req[1]; bus.m1_lock = r_lock[1]; bus.m1_write_enable = r_we[1];
    bus.m1_address = r_addr[1]; bus.m1_byte_enable = r_be[1]; bus.m1_write_data = r_wd[1];
  endtask

  task automatic setp(input int n, input logic rq, input logic lk, input logic w,
                      input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    r_req[n] = rq; r_lock[n] = lk; r_we[n] = w; r_addr[n] = a; r_be[n] = b; r_wd[n] = d;
    apply();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // behavioural reference model
  typedef struct { logic owner; logic [31:0] data; } ret_t;
  ret_t        retq[$];
  bit   [31:0] shadow [256] = '{64: 32'h1111_0100, 128: 32'h2222_0200, default: 32'h0};
  logic        m_last   = 1'b1;
  logic        m_locked = 1'b0;
  logic        m_owner  = 1'b0;
  int          m_count  = 0;
  logic        exp_gnt[2] = '{1'b0, 1'b0};

  initial begin : compare
    logic        rq[2], lk[2], we[2];
    logic [31:0] ad[2], wd[2];
    logic [3:0]  be[2];
    logic        gv, g;
    logic        ev[2];
    logic [31:0] ed[2];
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    ret_t        r;
    forever begin
      @(negedge clock);
      rq[0] = bus.m0_req; lk[0] = bus.m0_lock; we[0] = bus.m0_write_enable;
      ad[0] = bus.m0_address; be[0] = bus.m0_byte_enable; wd[0] = bus.m0_write_data;
      rq[1] = bus.m1_req; lk[1] = bus.m1_lock; we[1] = bus.m1_write_enable;
      ad[1] = bus.m1_address; be[1] = bus.m1_byte_enable; wd[1] = bus.m1_write_data;
      gv = 1'b0; g = 1'b0;
      ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = 32'h0; ed[1] = 32'h0;
      if (reset) begin
        m_last = 1'b1; m_locked = 1'b0; m_count = 0;
        retq.delete();
      end else begin
        if (retq.size() != 0) begin
          r = retq.pop_front();
          ev[r.owner] = 1'b1;
          ed[r.owner] = r.data;
        end
        if (m_locked && rq[m_owner]) begin
          gv = 1'b1; g = m_owner;
        end else if (rq[0] && rq[1]) begin
          gv = 1'b1; g = !m_last;
        end else if (rq[0] || rq[1]) begin
          gv = 1'b1; g = rq[1];
        end
      end
      e_addr = gv ? ad[g] : 32'h0;
      e_wd   = gv ? wd[g] : 32'h0;
      e_be   = !gv ? 4'h0 : (we[g] ? be[g] : 4'hF);

      check1 ("m0_grant",         bus.m0_grant,         gv && !g);
      check1 ("m1_grant",         bus.m1_grant,         gv && g);
      check32("mem_address",      bus.mem_address,      e_addr);
      check1 ("mem_read_enable",  bus.mem_read_enable,  gv && !we[g]);
      check1 ("mem_write_enable", bus.mem_write_enable, gv && we[g]);
      check32("mem_byte_enable",  32'(bus.mem_byte_enable), 32'(e_be));
      check32("mem_write_data",   bus.mem_write_data,   e_wd);
      check1 ("m0_read_valid",    bus.m0_read_valid,    ev[0]);
      check32("m0_read_data",     bus.m0_read_data,     ed[0]);
      check1 ("m1_read_valid",    bus.m1_read_valid,    ev[1]);
      check32("m1_read_data",     bus.m1_read_data,     ed[1]);

      if (!reset) begin
        if (gv) begin
          m_last = g;
          if (lk[g]) begin
            m_count  = (m_locked && m_owner == g) ? m_count + 1 : 1;
            m_owner  = g;
            m_locked = 1'b1;
            if (LOCK_MAX != 0 && m_count >= LOCK_MAX) begin
              m_locked = 1'b0; m_count = 0;
            end
          end else begin
            m_locked = 1'b0; m_count = 0;
          end
          if (we[g]) begin
            for (int b = 0; b < 4; b++) begin
              if (be[g][b]) shadow[ad[g][9:2]][8*b +: 8] = wd[g][8*b +: 8];
            end
          end else begin
            retq.push_back('{g, shadow[ad[g][9:2]]});
          end
        end else begin
          m_locked = 1'b0; m_count = 0;
        end
      end
      exp_gnt[0] = gv && !g;
      exp_gnt[1] = gv && g;
    end
  end

  initial begin : stimulus
    logic [7:0] seq;
    logic [4:0] seq6;
    logic       keep_lock;
    setp(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    setp(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    reset = 1'b1;
    setp(0, 1'b1, 1'b0, 1'b0, 32'h100, 4'h0, 32'h0);
    tick(); tick();
    @(negedge clock);
    check1 ("rst_m0_grant",        bus.m0_grant,        1'b0);
    check32("rst_mem_address",     bus.mem_address,     32'h0);
    check1 ("rst_mem_read_enable", bus.mem_read_enable, 1'b0);

    // alternating reads 0x100 / 0x200
    tick(); reset = 1'b0;
    setp(1, 1'b1, 1'b0, 1'b0, 32'h200, 4'h0, 32'h0);
    @(negedge clock);
    check1 ("t1c1_m0_grant", bus.m0_grant, 1'b1);
    check32("t1c1_addr",     bus.mem_address, 32'h100);
    tick(); @(negedge clock);
    check1 ("t1c2_m1_grant", bus.m1_grant, 1'b1);
    check32("t1c2_addr",     bus.mem_address, 32'h200);
    check1 ("t1c2_m0_valid", bus.m0_read_valid, 1'b1);
    check32("t1c2_m0_data",  bus.m0_read_data, 32'h1111_0100);
    tick(); @(negedge clock);
    check1 ("t1c3_m0_grant", bus.m0_grant, 1'b1);
    check32("t1c3_addr",     bus.mem_address, 32'h100);
    check32("t1c3_m1_data",  bus.m1_read_data, 32'h2222_0200);
    tick(); @(negedge clock);
    check1 ("t1c4_m1_grant", bus.m1_grant, 1'b1);
    check32("t1c4_addr",     bus.mem_address, 32'h200);
    check1 ("t1c4_m0_valid", bus.m0_read_valid, 1'b1);
    tick(); setp(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clock);
    check1 ("t1c5_m0_grant", bus.m0_grant, 1'b1);
    check1 ("t1c5_m1_valid", bus.m1_read_valid, 1'b1);
    tick(); setp(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clock);
    check1 ("t1c6_m0_valid", bus.m0_read_valid, 1'b1);

    // partial write then read back over zeroed memory
    tick(); setp(0, 1'b1, 1'b0, 1'b1, 32'h40, 4'b0011, 32'hDEAD_BEEF);
    @(negedge clock);
    check1 ("t2_write_enable", bus.mem_write_enable, 1'b1);
    check32("t2_byte_enable",  32'(bus.mem_byte_enable), 32'h3);
    check1 ("t2_read_enable",  bus.mem_read_enable, 1'b0);
    tick(); setp(0, 1'b1, 1'b0, 1'b0, 32'h40, 4'h0, 32'h0);
    @(negedge clock);
    check1 ("t2_no_valid_after_write", bus.m0_read_valid, 1'b0);
    check32("t2_read_be_forced",       32'(bus.mem_byte_enable), 32'hF);
    tick(); setp(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clock);
    check1 ("t2_read_valid", bus.m0_read_valid, 1'b1);
    check32("t2_read_data",  bus.m0_read_data, 32'h0000_BEEF);

    // m1 holds lock against a waiting m0, LOCK_MAX = 3
    tick();
    setp(0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    setp(1, 1'b1, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    seq = 8'b0111_0111;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      @(negedge clock);
      check1("t3_m1_grant", bus.m1_grant, seq[i]);
      check1("t3_m0_grant", bus.m0_grant, !seq[i]);
    end
    tick(); setp(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clock);
    check1("t3_tail_m1_grant", bus.m1_grant, 1'b1);
    tick(); setp(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // read accepted, then reset the next cycle
    tick(); setp(0, 1'b1, 1'b0, 1'b0, 32'h100, 4'h0, 32'h0);
    @(negedge clock);
    check1("t4_m0_grant", bus.m0_grant, 1'b1);
    tick(); reset = 1'b1;
    @(negedge clock);
    check1 ("t4_valid_in_reset",   bus.m0_read_valid, 1'b0);
    check1 ("t4_grant_in_reset",   bus.m0_grant, 1'b0);
    check32("t4_addr_in_reset",    bus.mem_address, 32'h0);
    check1 ("t4_re_in_reset",      bus.mem_read_enable, 1'b0);
    tick(); reset = 1'b0; setp(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clock);
    check1 ("t4_valid_after_reset", bus.m0_read_valid, 1'b0);
    check1 ("t5_idle_m0_grant",     bus.m0_grant, 1'b0);
    check1 ("t5_idle_m1_grant",     bus.m1_grant, 1'b0);
    check32("t5_idle_addr",         bus.mem_address, 32'h0);

    // lone m1 request right after reset
    tick(); setp(1, 1'b1, 1'b0, 1'b0, 32'h200, 4'h0, 32'h0);
    @(negedge clock);
    check1("t5_lone_m1_grant", bus.m1_grant, 1'b1);
    tick(); setp(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clock);
    check32("t5_m1_data", bus.m1_read_data, 32'h2222_0200);

    // both request lock: only the granted one acquires it
    tick();
    setp(0, 1'b1, 1'b1, 1'b1, 32'h8, 4'hF, 32'h1234_5678);
    setp(1, 1'b1, 1'b1, 1'b0, 32'hC, 4'h0, 32'h0);
    seq6 = 5'b01000;   // grant owner per cycle: 0,0,0,1,0
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      if (i == 2) setp(0, 1'b1, 1'b0, 1'b1, 32'h8, 4'hF, 32'h9ABC_DEF0);
      if (i == 4) setp(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clock);
      check1("t6_m1_grant", bus.m1_grant, seq6[i]);
      check1("t6_m0_grant", bus.m0_grant, !seq6[i]);
    end
    tick(); setp(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!(r_req[n] && !exp_gnt[n])) begin
          keep_lock = r_req[n] && r_lock[n] && exp_gnt[n];
          r_req[n]  = ($urandom_range(0, 99) < 65);
          if (keep_lock && r_req[n]) r_lock[n] = ($urandom_range(0, 99) < 85);
          else                       r_lock[n] = ($urandom_range(0, 3) == 0);
          r_we[n]   = 1'($urandom_range(0, 1));
          r_addr[n] = 32'($urandom_range(0, 31) << 2);
          r_be[n]   = 4'($urandom);
          r_wd[n]   = $urandom;
        end
      end
      apply();
    end
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single data-memory bus between two requesters: port 0 is the riscv_core load/store port, and port 1 is a loader/debug DMA port.
- Sits between the requesters and example_data_memory_bus.
- Round-robin arbitration with an optional lock that holds the grant across multi-beat transfers.
- Tracks the one outstanding read so returned data is steered to the requester that issued it.

Parameters:
- ADDR_WIDTH, 32, width of address buses.
- DATA_WIDTH, 32, width of data buses; byte-enable width is DATA_WIDTH/8.
- LOCK_MAX, 15, maximum consecutive locked grants before a forced handoff; 0 disables the limit.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  requester 0 wants the bus this cycle.
- m0_lock  input  1  requester 0 asks to keep the grant next cycle.
- m0_address  input  ADDR_WIDTH  requester 0 address.
- m0_write_enable  input  1  1 = write, 0 = read.
- m0_byte_enable  input  DATA_WIDTH/8  write byte lanes.
- m0_write_data  input  DATA_WIDTH  write data.
- m0_grant  output  1  request accepted this cycle (combinational).
- m0_read_valid  output  1  m0_read_data valid (registered).
- m0_read_data  output  DATA_WIDTH  returned read data.
- m1_*  same set as m0_* for requester 1.
- mem_address  output  ADDR_WIDTH  to memory.
- mem_read_enable  output  1  to memory.
- mem_write_enable  output  1  to memory.
- mem_byte_enable  output  DATA_WIDTH/8  to memory.
- mem_write_data  output  DATA_WIDTH  to memory.
- mem_read_data  input  DATA_WIDTH  from memory, valid the cycle after mem_read_enable.

Behaviour:
State registers:
- last_grant (1b).
- locked (1b) and lock_owner (1b).
- lock_count (4b min, ceil(log2(LOCK_MAX+1))).
- rd_pending (1b) and rd_owner (1b).

Reset:
- last_grant = 1, so m0 wins the first tie.
- locked = 0, lock_count = 0, rd_pending = 0.
- All grants and read_valids are 0.
- All mem_* outputs are 0.

Grant (combinational, same cycle as req):
- If locked and the lock owner's req = 1, the owner is granted.
- Else if exactly one req, that requester is granted.
- Else if both req, the requester != last_grant is granted.
- Else no grant.
- At most one grant per cycle.
- With no grant: mem_read_enable = mem_write_enable = 0, and mem_address/mem_write_data/mem_byte_enable = 0.
- With a grant: mem_* mirror the granted requester's fields.
  - mem_read_enable = ~write_enable.
  - mem_write_enable = write_enable.
  - Byte enable is passed through for writes and forced to all ones for reads.

Per-cycle updates (posedge, not in reset):
- On a grant to requester g: last_grant <= g.
- Lock set: on a grant with g's lock = 1, locked <= 1, lock_owner <= g, lock_count <= lock_count + 1.
- Lock release (locked <= 0, lock_count <= 0) when any of:
  - the owner deasserts lock on a granted cycle;
  - the owner deasserts req;
  - LOCK_MAX != 0 and lock_count reaches LOCK_MAX.
- LOCK_MAX handoff: the following cycle is arbitrated normally with last_grant = owner, so a waiting other requester wins.
- Read tracking: a granted read sets rd_pending <= 1 and rd_owner <= g; otherwise rd_pending <= 0.

Read return:
- mN_read_valid = rd_pending && rd_owner == N, i.e. exactly one cycle after the accepted read.
- mN_read_data = mem_read_data when mN is the valid owner, else 0.

Latency and throughput:
- Fixed read latency of 1 cycle.
- Reads and writes can issue back-to-back every cycle.
- A read in cycle N followed by any grant in N+1 is legal; return and new issue overlap.
- Writes never produce read_valid.

Boundary conditions:
- A requester not granted must hold req and fields stable until granted.
- Reset asserted while rd_pending: no read_valid is emitted in the cycle after reset.
- Simultaneous lock from both requesters: only the granted one acquires the lock.
- lock with req = 0 is ignored.
- A lock request when LOCK_MAX = 0 never forces a handoff.

Test Plan:
- Reset then m0_req = m1_req = 1 reads at 0x100/0x200 for 4 cycles:
  - grants alternate m0, m1, m0, m1;
  - mem_address 0x100, 0x200, 0x100, 0x200;
  - each mN_read_valid pulses one cycle after its grant, carrying memory contents.
- m0 write addr 0x40, data 0xDEADBEEF, byte_enable 4'b0011:
  - mem_write_enable = 1 and mem_byte_enable = 0011 in the same cycle;
  - no read_valid the next cycle;
  - a subsequent m0 read of 0x40 returns 0x0000BEEF over zeroed memory.
- m1 holds lock = 1 and req = 1 with m0_req = 1 continuously, LOCK_MAX = 3:
  - m1 is granted 3 consecutive cycles, then m0 is granted;
  - lock_count returns to 0.
- m0 read granted in cycle N, reset asserted in cycle N+1:
  - m0_read_valid = 0 in N+1 and N+2;
  - all mem_* outputs = 0 while reset is high.
- Idle, neither req:
  - all mem_* = 0, no grants;
  - a lone m1_req gets immediate same-cycle grant even though last_grant = 1 after reset.
